split_tmo: RTL and testbench
============================

Name: split_tmo

Overview:
- Parametrised, registered successor to the single-master native-bus `split`. It routes one master request to one of N_SLAVES slaves, selected by an address field.
- Adds three things the plain split does not have:
  - registered request and response stages, for timing closure on the peripheral bus;
  - an immediate error response for unmapped select codes;
  - a per-transaction timeout watchdog that terminates hung slaves with an error word and a sticky error report.
- Sits between `dbus_split` and the peripherals.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- N_SLAVES, 4, number of slave ports (>=1).
- P_SLAVES, 31, MSB bit position of the select field in addr.
- TIMEOUT_CYC, 1024, cycles a slave may take before abort; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF, rdata returned on error responses (DATA_W bits).

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-low
- m_req  in  REQ_W  master request {valid, addr, wdata, wstrb}, MSB first; REQ_W = 1+ADDR_W+DATA_W+DATA_W/8
- m_resp  out  RESP_W  master response {rdata, ready}; RESP_W = DATA_W+1
- s_req  out  N_SLAVES*REQ_W  slave requests; slot k at bits [k*REQ_W +: REQ_W]
- s_resp  in  N_SLAVES*RESP_W  slave responses; slot k at bits [k*RESP_W +: RESP_W]
- err_clr  in  1  clears the sticky error state
- err  out  1  sticky: an error response has occurred
- err_tmo  out  1  type of last error: 1 = timeout, 0 = unmapped
- err_addr  out  ADDR_W  address of the last errored request

Behaviour:
- SEL_W = max(1, clog2(N_SLAVES)). sel = addr[P_SLAVES -: SEL_W] of the latched request. sel >= N_SLAVES is unmapped.
- Master protocol: master holds valid and fields stable until it sees ready high. ready is a one-cycle pulse. rdata is valid only with ready.
- Reset (rst=0, async), all cleared immediately:
  - state = IDLE; all s_req = 0; m_resp = 0; err = 0; err_tmo = 0; err_addr = 0; timeout counter = 0.
  - A reset mid-transaction drops s_valid at once; no response is ever issued for that transaction.
- State machine:
  - IDLE: if m_valid, latch addr/wdata/wstrb into the request register and clear the counter.
    - sel mapped: go to FWD.
    - sel unmapped: go to ERR.
  - FWD:
    - s_req slot sel = {1, latched fields}; all other slots are all-zero.
    - If s_ready[sel]: register s_rdata[sel] into the response data; go to RESP.
    - Else, if TIMEOUT_CYC != 0 and counter == TIMEOUT_CYC-1: load ERR_DATA; err=1, err_tmo=1, err_addr=latched addr; go to RESP.
    - Else increment the counter.
    - s_valid is deasserted on the cycle after the slave's ready or the timeout.
  - ERR: load ERR_DATA; err=1, err_tmo=0, err_addr=latched addr; go to RESP.
  - RESP: m_ready=1 for exactly one cycle, with m_rdata = registered data; go to IDLE.
- Latency:
  - mapped request: m_valid seen at edge 0; s_valid high in cycle 1; slave ready in cycle 1+L gives m_ready in cycle 2+L (minimum 2 cycles).
  - unmapped request: m_ready in cycle 2.
  - timeout: s_valid high exactly TIMEOUT_CYC cycles, then m_ready on the next cycle.
- Back-to-back: the master may present a new valid in the cycle after m_ready. IDLE accepts it, with no dead cycle beyond IDLE itself.
- m_rdata is held at its last value outside ready; benches must check it only on ready.
- Late slave: an s_ready arriving in RESP or IDLE after a timeout abort is ignored.
- Error clearing:
  - err_clr=1 clears err, err_tmo and err_addr on the next edge.
  - If err_clr and a new error event occur in the same cycle, the new error wins and is recorded.
- No combinational path exists from s_resp or m_req to any output; all outputs are registered.

Test Plan:
- Read, slave 2, ready after 3 cycles:
  - Stimulus: addr=0x8000_0010 (sel=2, default params), slave 2 returns rdata=0x1234_5678.
  - Required: s_valid[2] high for cycles 1–4 only; other slots zero; m_ready in cycle 5 with rdata 0x1234_5678; err=0.
- Write, slave 0, zero-wait:
  - Stimulus: wdata=0xA5A5_A5A5, wstrb=4'b0011, slave 0 ready in cycle 1.
  - Required: slot 0 carries the exact wdata/wstrb; m_ready in cycle 2.
- Unmapped select:
  - Stimulus: N_SLAVES=3, addr=0xC000_0000.
  - Required: no s_valid ever; m_ready in cycle 2 with rdata 0xDEADBEEF; err=1, err_tmo=0, err_addr=0xC000_0000.
- Timeout abort:
  - Stimulus: TIMEOUT_CYC=8, slave 1 never ready.
  - Required: s_valid[1] high exactly 8 cycles; m_ready next cycle with 0xDEADBEEF; err_tmo=1.
  - Then a late s_ready[1] is ignored, and a following slave 3 read completes normally.
- err_clr and error in the same cycle:
  - Required: err stays 1 and err_addr updates to the new address.
  - Afterwards, err_clr alone clears all three error outputs to 0 on the next edge.
- Async reset mid-FWD:
  - Stimulus: drive rst low between clock edges while in FWD.
  - Required: s_req and m_resp go to 0 immediately.
  - After release: no stale m_ready; a new request completes normally.

Source files
------------

// File: rtl/split_tmo.sv
// Registered single-master splitter: routes one request to a slave chosen by an
// address field, answers unmapped selects with an error and aborts hung slaves.
module split_tmo #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                N_SLAVES    = 4,
  parameter int                P_SLAVES    = 31,
  parameter int                TIMEOUT_CYC = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(32'hDEADBEEF),
  localparam int               STRB_W      = DATA_W / 8,
  localparam int               REQ_W       = 1 + ADDR_W + DATA_W + STRB_W,
  localparam int               RESP_W      = DATA_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_W-1:0]             m_req,
  output logic [RESP_W-1:0]            m_resp,
  output logic [N_SLAVES*REQ_W-1:0]    s_req,
  input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
  input  logic                         err_clr,
  output logic                         err,
  output logic                         err_tmo,
  output logic [ADDR_W-1:0]            err_addr
);

  localparam int              SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SEL_W:0]  N_MAP    = (SEL_W + 1)'(N_SLAVES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit              TMO_EN   = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {IDLE, FWD, ERR, RESP} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rdata_q;

  logic                m_valid;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [STRB_W-1:0]   m_wstrb;
  logic [SEL_W-1:0]    sel_in, sel_q;
  logic                in_mapped;
  logic                slv_ready;
  logic [DATA_W-1:0]   slv_rdata;
  logic                tmo_hit;
  logic                err_evt, evt_tmo;

  assign m_valid   = m_req[REQ_W-1];
  assign m_addr    = m_req[REQ_W-2 -: ADDR_W];
  assign m_wdata   = m_req[STRB_W +: DATA_W];
  assign m_wstrb   = m_req[STRB_W-1:0];
  assign sel_in    = m_addr[P_SLAVES -: SEL_W];
  assign sel_q     = addr_q[P_SLAVES -: SEL_W];
  assign in_mapped = ({1'b0, sel_in} < N_MAP);
  assign tmo_hit   = TMO_EN && (cnt == CNT_LAST);

  // Slave request fan-out and response select are driven only from registered state.
  always_comb begin
    s_req     = '0;
    slv_ready = 1'b0;
    slv_rdata = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        slv_ready = s_resp[k*RESP_W];
        slv_rdata = s_resp[k*RESP_W+1 +: DATA_W];
        if (state == FWD)
          s_req[k*REQ_W +: REQ_W] = {1'b1, addr_q, wdata_q, wstrb_q};
      end
    end
  end

  always_comb begin
    state_n = state;
    err_evt = 1'b0;
    evt_tmo = 1'b0;
    case (state)
      IDLE: if (m_valid) state_n = in_mapped ? FWD : ERR;
      FWD: begin
        if (slv_ready) begin
          state_n = RESP;
        end else if (tmo_hit) begin
          state_n = RESP;
          err_evt = 1'b1;
          evt_tmo = 1'b1;
        end
      end
      ERR: begin
        state_n = RESP;
        err_evt = 1'b1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
      err      <= 1'b0;
      err_tmo  <= 1'b0;
      err_addr <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (m_valid) begin
            addr_q  <= m_addr;
            wdata_q <= m_wdata;
            wstrb_q <= m_wstrb;
            cnt     <= '0;
          end
        end
        FWD: begin
          if (slv_ready)    rdata_q <= slv_rdata;
          else if (tmo_hit) rdata_q <= ERR_DATA;
          else              cnt     <= cnt + 1'b1;
        end
        ERR:     rdata_q <= ERR_DATA;
        default: ;
      endcase
      // A fresh error outranks a simultaneous clear.
      if (err_evt) begin
        err      <= 1'b1;
        err_tmo  <= evt_tmo;
        err_addr <= addr_q;
      end else if (err_clr) begin
        err      <= 1'b0;
        err_tmo  <= 1'b0;
        err_addr <= '0;
      end
    end
  end

  assign m_resp = {rdata_q, (state == RESP)};

endmodule

// File: tb/tb_split_tmo.sv
// Scoreboard bench for split_tmo: driver predicts each response from the routing
// rules, a monitor checks every m_ready against the predicted queue.
module tb_split_tmo;
  localparam int AW = 32, DW = 32, NS = 3, TMO = 8, SW = 4;
  localparam int REQ_W = 1 + AW + DW + SW, RESP_W = DW + 1;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic                     clk;
  logic                     rst;
  logic [REQ_W-1:0]         m_req;
  logic [RESP_W-1:0]        m_resp;
  logic [NS*REQ_W-1:0]      s_req;
  logic [NS*RESP_W-1:0]     s_resp;
  logic                     err_clr;
  logic                     err;
  logic                     err_tmo;
  logic [AW-1:0]            err_addr;

  split_tmo #(
    .ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS), .P_SLAVES(31),
    .TIMEOUT_CYC(TMO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp),
    .s_req(s_req), .s_resp(s_resp), .err_clr(err_clr),
    .err(err), .err_tmo(err_tmo), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    logic [31:0] eaddr;
  } exp_t;

  exp_t        sbq[$];
  logic        mdl_err = 1'b0;
  logic        mdl_tmo = 1'b0;
  logic [31:0] mdl_eaddr = '0;

  // Slave behaviour: lat[k] wait cycles before ready (-1 = never), late[k] forces stray readies.
  int          lat[NS];
  logic [31:0] sdat[NS];
  int          vcnt[NS];
  int          late[NS];

  initial begin
    s_resp = '0;
    for (int k = 0; k < NS; k++) begin
      lat[k] = 0; sdat[k] = '0; vcnt[k] = 0; late[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NS; k++) begin
        logic rdy;
        rdy = 1'b0;
        if (s_req[k*REQ_W + REQ_W - 1]) begin
          if (lat[k] >= 0 && vcnt[k] == lat[k]) rdy = 1'b1;
          vcnt[k]++;
        end else begin
          vcnt[k] = 0;
        end
        if (late[k] > 0) begin
          rdy = 1'b1;
          late[k]--;
        end
        s_resp[k*RESP_W +: RESP_W] = {rdy ? sdat[k] : 32'($urandom()), rdy};
      end
    end
  end

  // Monitor: every m_ready must match the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && m_resp[0] === 1'b1) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_ready: got ready with rdata %0h, required no response (t=%0t)",
                   m_resp[RESP_W-1:1], $time);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("rdata", m_resp[RESP_W-1:1], e.rdata);
          check("err", err, e.err);
          check("err_tmo", err_tmo, e.tmo);
          check("err_addr", err_addr, e.eaddr);
        end
      end
    end
  end

  // One master transaction; clr_cyc>0 pulses err_clr for the edge ending that cycle.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int clr_cyc);
    exp_t e;
    int   s, exp_lat, exp_sv, sv;
    logic got;
    logic [REQ_W-1:0] slot;
    s = int'(addr[31:30]);
    if (s >= NS) begin
      e.rdata = ERRD; mdl_err = 1'b1; mdl_tmo = 1'b0; mdl_eaddr = addr;
      exp_lat = 2; exp_sv = 0;
    end else if (lat[s] >= 0 && lat[s] < TMO) begin
      e.rdata = sdat[s];
      exp_lat = 2 + lat[s]; exp_sv = lat[s] + 1;
    end else begin
      e.rdata = ERRD; mdl_err = 1'b1; mdl_tmo = 1'b1; mdl_eaddr = addr;
      exp_lat = TMO + 1; exp_sv = TMO;
    end
    e.err = mdl_err; e.tmo = mdl_tmo; e.eaddr = mdl_eaddr;
    sbq.push_back(e);

    @(negedge clk);
    m_req = {1'b1, addr, wdata, wstrb};
    @(posedge clk);
    got = 1'b0;
    sv = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      err_clr = (c == clr_cyc);
      for (int k = 0; k < NS; k++) begin
        slot = s_req[k*REQ_W +: REQ_W];
        if (k == s && slot[REQ_W-1]) begin
          sv++;
          check("slot_fields", slot, m_req);
        end else begin
          check("slot_idle", slot, '0);
        end
      end
      if (m_resp[0] === 1'b1) begin
        got = 1'b1;
        check("latency", c, exp_lat);
      end
    end
    check("ready_seen", got, 1'b1);
    check("svalid_cycles", sv, exp_sv);
    m_req = '0;
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0;
    m_req = '0;
    err_clr = 1'b0;
    #1;
    check("rst_s_req", s_req, '0);
    check("rst_m_resp", m_resp, '0);
    check("rst_err", {err, err_tmo}, 2'b00);
    check("rst_err_addr", err_addr, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Read from slave 2 with three wait cycles.
    lat[2] = 3; sdat[2] = 32'h1234_5678;
    txn(32'h8000_0010, 32'h0, 4'h0, 0);
    // Zero-wait write to slave 0.
    lat[0] = 0; sdat[0] = 32'h0BAD_F00D;
    txn(32'h0000_0040, 32'hA5A5_A5A5, 4'b0011, 0);
    // Unmapped select.
    txn(32'hC000_0000, 32'h0, 4'h0, 0);
    // Hung slave 1, then stray readies on slot 1 while the next read runs on slave 2.
    lat[1] = -1;
    txn(32'h4000_0004, 32'h1111_2222, 4'hF, 0);
    late[1] = 2;
    lat[2] = 1; sdat[2] = 32'hCAFE_0002;
    txn(32'h8000_0020, 32'h0, 4'h0, 0);
    // Clear coinciding with a new unmapped error: the error is kept.
    txn(32'hC000_0100, 32'h0, 4'h0, 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    mdl_err = 1'b0; mdl_tmo = 1'b0; mdl_eaddr = '0;
    check("clr_err", err, mdl_err);
    check("clr_err_tmo", err_tmo, mdl_tmo);
    check("clr_err_addr", err_addr, mdl_eaddr);

    // Asynchronous reset while forwarding to a hung slave.
    txn(32'hFFFF_0000, 32'h0, 4'h0, 0);
    @(negedge clk);
    m_req = {1'b1, 32'h4000_0008, 32'h5555_AAAA, 4'hC};
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_s_req", s_req, '0);
    check("arst_m_resp", m_resp, '0);
    check("arst_err", {err, err_tmo}, 2'b00);
    check("arst_err_addr", err_addr, '0);
    mdl_err = 1'b0; mdl_tmo = 1'b0; mdl_eaddr = '0;
    m_req = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_s_req", s_req, '0);
    lat[0] = 2; sdat[0] = 32'h7777_0000;
    txn(32'h0000_1000, 32'h0, 4'h0, 0);

    // Randomised traffic, including timeouts at and beyond the limit.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int          sl, l;
      a = $urandom();
      sl = int'(a[31:30]);
      l = $urandom_range(0, 9);
      if (sl < NS) begin
        lat[sl] = (l == 9) ? -1 : l;
        sdat[sl] = $urandom();
      end
      txn(a, $urandom(), 4'($urandom()), 0);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        mdl_err = 1'b0; mdl_tmo = 1'b0; mdl_eaddr = '0;
        check("rand_clr", {err, err_tmo, err_addr}, {mdl_err, mdl_tmo, mdl_eaddr});
      end
    end

    repeat (4) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
